rb_write_ctrl: RTL and testbench
================================

RB_WRITE_CTRL -- requirements
Module: rb_write_ctrl

Interface
REQ-001 SHALL take params: BRAMs, 4, row-buffer BRAM count.
REQ-002 SHALL take params: BRAM_ADDR, 2, BRAM select width.
REQ-003 SHALL take params: BRAM_DEPTH_ADDR, 9, word address width.
REQ-004 SHALL take params: BRAM_W_DATA_WIDTH, 32, write word width.
REQ-005 SHALL take params: PIXEL_WIDTH, 8, pixel bits; IMG_WIDTH, 16, pixels/row; IMG_HEIGHT, 8, rows/frame.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: pix_valid  in  1  pixel offered; pix_data  in  PIXEL_WIDTH  pixel; sof  in  1  qualifies first pixel of frame.
REQ-009 SHALL have ports: pix_ready  out  1  pixel accepted when valid&ready.
REQ-010 SHALL have ports: row_release  in  1  reader frees oldest buffered row (1-cycle pulse).
REQ-011 SHALL have ports: EN_A  out  1; BRAM_W  out  BRAM_ADDR; ADDR_A  out  BRAM_DEPTH_ADDR; DIN_A  out  BRAM_W_DATA_WIDTH -- write-port drive.
REQ-012 SHALL have ports: row_done  out  1  pulse per completed row; frame_done  out  1  pulse after last row; rows_filled  out  BRAM_ADDR+1  occupied rows.

Function
REQ-013 SHALL pack PPW = BRAM_W_DATA_WIDTH/PIXEL_WIDTH pixels/word, pixel col c in lane c%PPW, bits [PIXEL_WIDTH*(c%PPW)+:PIXEL_WIDTH].
REQ-014 SHALL use FSM states IDLE, WRITE, FULL, DONE.
REQ-015 SHALL, in IDLE, hold pix_ready=1; consume and drop pixels without sof; go to WRITE on accepting a pixel with sof (pixel stored as col 0, row 0).
REQ-016 SHALL, in WRITE, register EN_A=1 for exactly one cycle, one cycle after accepting the pixel that completes a word; ADDR_A=c/PPW, BRAM_W=row%BRAMs, DIN_A=packed word.
REQ-017 SHALL hold EN_A=0 and DIN_A/ADDR_A/BRAM_W unchanged otherwise.
REQ-018 SHALL, after col IMG_WIDTH-1, reset col to 0, pulse row_done with that write, increment rows_filled, advance BRAM_W, wrapping BRAMs-1 -> 0.
REQ-019 SHALL decrement rows_filled on row_release when nonzero; leave it unchanged on simultaneous row_done and row_release; ignore release at zero.
REQ-020 SHALL enter FULL when rows_filled reaches BRAMs; pix_ready=0 in FULL; return to WRITE the cycle after a release.
REQ-021 SHALL enter DONE after row IMG_HEIGHT-1 completes; pulse frame_done one cycle; return to IDLE next cycle, col/row cleared, rows_filled kept.
REQ-022 SHALL restart the frame (col=row=0, partial word discarded, no write) on sof accepted mid-frame in WRITE.

Reset
REQ-023 SHALL on rst force IDLE, EN_A=0, BRAM_W=0, ADDR_A=0, DIN_A=0, row_done=0, frame_done=0, rows_filled=0, pix_ready=0; pix_ready=1 first cycle after deassertion.
REQ-024 SHALL abandon any in-progress word or row on reset mid-frame with no write issued.

Configuration
REQ-025 SHALL with RB_WR_PARTIAL_FLUSH_EN defined: if IMG_WIDTH%PPW!=0, write the final partial word of each row with unused lanes zero.
REQ-026 SHALL without RB_WR_PARTIAL_FLUSH_EN: IMG_WIDTH%PPW must be 0, checked by elaboration error.

Structure
REQ-027 SHALL take BRAM params from the shared par.vh parameter include; FSM state encodings and PPW belong in the same package.
REQ-028 SHALL use one sub-module, rb_pixel_packer (lane shift register plus word-complete flag); counters/FSM stay in rb_write_ctrl.

Verification
REQ-029 SHALL verify: reset, sof, pixels 0x01..0x04 -> one EN_A, BRAM_W=0, ADDR_A=0, DIN_A=0x04030201, one cycle after 4th accept.
REQ-030 SHALL verify: 4 full rows of 16 px, no release -> writes BRAM_W 0..3, rows_filled=4, pix_ready=0 (FULL); one row_release -> ready next cycle, next row to BRAM_W=0.
REQ-031 SHALL verify: row_done and row_release same cycle with rows_filled=2 -> stays 2.
REQ-032 SHALL verify: 8 rows streamed with releases -> frame_done single pulse after 8th row_done, FSM in IDLE.
REQ-033 SHALL verify: rst asserted after 2 pixels of a word -> no EN_A; after release, sof frame starts at ADDR_A=0, BRAM_W=0.
REQ-034 SHALL verify: with RB_WR_PARTIAL_FLUSH_EN, IMG_WIDTH=6, pixels 0x11..0x16 -> DIN_A 0x14131211 at ADDR_A=0, then 0x00001615 at ADDR_A=1 with row_done.

Source files
------------

// File: rtl/rb_write_ctrl_pkg.sv
// Shared parameters, FSM state encoding and pixels-per-word helpers for the
// row-buffer write controller.
package rb_write_ctrl_pkg;

  localparam int unsigned BRAMS_DEF             = 4;
  localparam int unsigned BRAM_ADDR_DEF         = 2;
  localparam int unsigned BRAM_DEPTH_ADDR_DEF   = 9;
  localparam int unsigned BRAM_W_DATA_WIDTH_DEF = 32;
  localparam int unsigned PIXEL_WIDTH_DEF       = 8;
  localparam int unsigned IMG_WIDTH_DEF         = 16;
  localparam int unsigned IMG_HEIGHT_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned calc_ppw(input int unsigned data_w, input int unsigned pix_w);
    return data_w / pix_w;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PPW_DEF = calc_ppw(BRAM_W_DATA_WIDTH_DEF, PIXEL_WIDTH_DEF);

endpackage

// File: rtl/rb_pixel_packer.sv
// Collects pixels into word lanes; flags when the accepted pixel closes a word.
module rb_pixel_packer
  import rb_write_ctrl_pkg::*;
#(
  parameter int unsigned PPW         = PPW_DEF,
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int unsigned LANE_W      = idx_w(PPW)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic                         clr,
  input  logic                         flush,
  input  logic [LANE_W-1:0]            lane,
  input  logic [PIXEL_WIDTH-1:0]       pix,
  output logic [PPW*PIXEL_WIDTH-1:0]   word_c,
  output logic                         done_c
);

  logic [PPW-1:0][PIXEL_WIDTH-1:0] lanes;
  logic [PPW-1:0][PIXEL_WIDTH-1:0] lanes_nxt;

  // Current pixel merged into the held lanes; clr drops an abandoned word.
  always_comb begin
    lanes_nxt       = clr ? '0 : lanes;
    lanes_nxt[lane] = pix;
  end

  assign word_c = lanes_nxt;
  assign done_c = accept & ((lane == LANE_W'(PPW - 1)) | flush);

  // Lanes return to zero after each word so a flushed word has empty upper lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
    end else if (accept) begin
      lanes <= done_c ? '0 : lanes_nxt;
    end
  end

endmodule

// File: rtl/rb_write_ctrl.sv
// Row-buffer write controller: packs a pixel stream into BRAM words, one row per BRAM.
// Optional RB_WR_PARTIAL_FLUSH_EN writes a zero-padded last word when rows are not word aligned.
module rb_write_ctrl
  import rb_write_ctrl_pkg::*;
#(
  parameter int unsigned BRAMs             = BRAMS_DEF,
  parameter int unsigned BRAM_ADDR         = BRAM_ADDR_DEF,
  parameter int unsigned BRAM_DEPTH_ADDR   = BRAM_DEPTH_ADDR_DEF,
  parameter int unsigned BRAM_W_DATA_WIDTH = BRAM_W_DATA_WIDTH_DEF,
  parameter int unsigned PIXEL_WIDTH       = PIXEL_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH         = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT        = IMG_HEIGHT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  input  logic [PIXEL_WIDTH-1:0]       pix_data,
  input  logic                         sof,
  output logic                         pix_ready,
  input  logic                         row_release,
  output logic                         EN_A,
  output logic [BRAM_ADDR-1:0]         BRAM_W,
  output logic [BRAM_DEPTH_ADDR-1:0]   ADDR_A,
  output logic [BRAM_W_DATA_WIDTH-1:0] DIN_A,
  output logic                         row_done,
  output logic                         frame_done,
  output logic [BRAM_ADDR:0]           rows_filled
);

  localparam int unsigned PPW    = calc_ppw(BRAM_W_DATA_WIDTH, PIXEL_WIDTH);
  localparam int unsigned COL_W  = idx_w(IMG_WIDTH);
  localparam int unsigned ROW_W  = idx_w(IMG_HEIGHT);
  localparam int unsigned LANE_W = idx_w(PPW);
  localparam int unsigned RF_W   = BRAM_ADDR + 1;

  state_e state;
  state_e state_nxt;

  logic [COL_W-1:0]         col, cur_col;
  logic [ROW_W-1:0]         row, cur_row;
  logic [BRAM_ADDR-1:0]     sel, cur_sel;
  logic [LANE_W-1:0]        lane;
  logic [PPW*PIXEL_WIDTH-1:0] word;
  logic [RF_W-1:0]          rows_filled_nxt;
  logic accept, start, in_frame, word_done, flush;
  logic wr, last_col, last_row, row_end, rel;
  logic pix_ready_nxt, en_nxt, row_done_nxt, frame_done_nxt;

  assign accept   = pix_valid & pix_ready;
  assign start    = accept & sof & ((state == IDLE) | (state == WRITE));
  assign in_frame = start | (accept & (state == WRITE));

  // A sof pixel always lands at column 0 of row 0, restarting any frame in progress.
  assign cur_col  = start ? '0 : col;
  assign cur_row  = start ? '0 : row;
  assign cur_sel  = start ? '0 : sel;
  assign lane     = LANE_W'(32'(cur_col) % PPW);
  assign last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
  assign last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
  assign wr       = word_done;
  assign row_end  = wr & last_col;
  assign rel      = row_release & (rows_filled != '0);

`ifdef RB_WR_PARTIAL_FLUSH_EN
  assign flush = last_col;
`else
  assign flush = 1'b0;
  if (IMG_WIDTH % PPW != 0) begin : g_width_check
    $error("rb_write_ctrl: IMG_WIDTH must be a multiple of pixels per word");
  end
`endif

  rb_pixel_packer #(
    .PPW         (PPW),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .LANE_W      (LANE_W)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .accept (in_frame),
    .clr    (start),
    .flush  (flush),
    .lane   (lane),
    .pix    (pix_data),
    .word_c (word),
    .done_c (word_done)
  );

  // Occupancy counts a row once its row_done pulse is visible, so a release in that cycle cancels it.
  always_comb begin
    rows_filled_nxt = rows_filled;
    if (row_done && !rel) begin
      rows_filled_nxt = rows_filled + RF_W'(1);
    end else if (!row_done && rel) begin
      rows_filled_nxt = rows_filled - RF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A completing row is counted ahead of its pending increment to stop before overwriting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE: begin
        if (row_end && last_row) begin
          state_nxt = DONE;
        end else if (row_end && ((rows_filled_nxt + RF_W'(1)) >= RF_W'(BRAMs))) begin
          state_nxt = FULL;
        end else if (in_frame && (rows_filled_nxt >= RF_W'(BRAMs))) begin
          state_nxt = FULL;
        end else if (start) begin
          state_nxt = WRITE;
        end
      end
      FULL:    if (rel) state_nxt = WRITE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready_nxt  = (state_nxt == IDLE) || (state_nxt == WRITE);
    en_nxt         = wr;
    row_done_nxt   = row_end;
    frame_done_nxt = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_ready   <= 1'b0;
      EN_A        <= 1'b0;
      BRAM_W      <= '0;
      ADDR_A      <= '0;
      DIN_A       <= '0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      rows_filled <= '0;
    end else begin
      pix_ready   <= pix_ready_nxt;
      EN_A        <= en_nxt;
      row_done    <= row_done_nxt;
      frame_done  <= frame_done_nxt;
      rows_filled <= rows_filled_nxt;
      if (wr) begin
        BRAM_W <= cur_sel;
        ADDR_A <= BRAM_DEPTH_ADDR'(32'(cur_col) / PPW);
        DIN_A  <= BRAM_W_DATA_WIDTH'(word);
      end
    end
  end

  // Column, row and BRAM select; cleared when the frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      sel <= '0;
    end else if (state == DONE) begin
      col <= '0;
      row <= '0;
      sel <= '0;
    end else if (in_frame) begin
      if (last_col) begin
        col <= '0;
        row <= cur_row + ROW_W'(1);
        sel <= (cur_sel == BRAM_ADDR'(BRAMs - 1)) ? '0 : cur_sel + BRAM_ADDR'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
        sel <= cur_sel;
      end
    end
  end

endmodule

// File: tb/tb_rb_write_ctrl.sv
// Scoreboard bench for rb_write_ctrl; expected BRAM writes are queued as pixels are accepted.
module tb_rb_write_ctrl;

  localparam int unsigned PW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned PPW = DW / PW;
  localparam int unsigned NB  = 4;
  localparam int unsigned IH  = 8;
`ifdef RB_WR_PARTIAL_FLUSH_EN
  localparam int unsigned IW    = 6;
  localparam bit          FLUSH = 1'b1;
`else
  localparam int unsigned IW    = 16;
  localparam bit          FLUSH = 1'b0;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic [8:0]  addr;
    logic [31:0] din;
    logic        rd;
    int          due;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        sof = 1'b0;
  logic        row_release = 1'b0;
  logic        pix_ready;
  logic        EN_A;
  logic [1:0]  BRAM_W;
  logic [8:0]  ADDR_A;
  logic [31:0] DIN_A;
  logic        row_done;
  logic        frame_done;
  logic [2:0]  rows_filled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  wr_t q[$];

  int          m_col = 0;
  int          m_row = 0;
  bit          m_active = 1'b0;
  logic [31:0] m_word = '0;

  rb_write_ctrl #(
    .BRAMs(NB), .BRAM_ADDR(2), .BRAM_DEPTH_ADDR(9), .BRAM_W_DATA_WIDTH(DW),
    .PIXEL_WIDTH(PW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
    .pix_ready(pix_ready), .row_release(row_release), .EN_A(EN_A), .BRAM_W(BRAM_W),
    .ADDR_A(ADDR_A), .DIN_A(DIN_A), .row_done(row_done), .frame_done(frame_done),
    .rows_filled(rows_filled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s);
    wr_t it;
    if (s) begin
      m_active = 1'b1; m_col = 0; m_row = 0; m_word = '0;
    end
    if (!m_active) return;
    m_word[PW*(m_col % PPW) +: PW] = d;
    if ((m_col % PPW) == PPW - 1 || (FLUSH && m_col == IW - 1)) begin
      it.sel  = 2'(m_row % NB);
      it.addr = 9'(m_col / PPW);
      it.din  = m_word;
      it.rd   = (m_col == IW - 1);
      it.due  = cyc;
      q.push_back(it);
      m_word = '0;
    end
    if (m_col == IW - 1) begin
      m_col = 0;
      m_row++;
      if (m_row == IH) m_active = 1'b0;
    end else begin
      m_col++;
    end
  endtask

  // Offers one pixel and returns just after the clock edge that accepts it.
  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    @(negedge clk);
    pix_valid = 1'b1; pix_data = d; sof = s;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      chk("ready_timeout", 64'(pix_ready), 64'd1);
      pix_valid = 1'b0; sof = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0; sof = 1'b0;
    model_accept(d, s);
  endtask

  task automatic send_rows(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < IW; c++) send(8'($urandom), 1'b0);
  endtask

  task automatic release_row();
    @(negedge clk); row_release = 1'b1;
    @(negedge clk); row_release = 1'b0;
  endtask

  // Write monitor: every EN_A must match the head of the scoreboard in the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (EN_A) begin
        if (q.size() == 0) begin
          chk("wr_unexpected", 64'(EN_A), 64'd0);
        end else begin
          wr_t it;
          it = q.pop_front();
          chk("wr_latency", 64'(cyc), 64'(it.due));
          chk("bram_w", 64'(BRAM_W), 64'(it.sel));
          chk("addr_a", 64'(ADDR_A), 64'(it.addr));
          chk("din_a", 64'(DIN_A), 64'(it.din));
          chk("row_done", 64'(row_done), 64'(it.rd));
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk("wr_missing", 64'(cyc), 64'(q[0].due));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en_a", 64'(EN_A), 64'd0);
    chk("rst_bram_w", 64'(BRAM_W), 64'd0);
    chk("rst_addr_a", 64'(ADDR_A), 64'd0);
    chk("rst_din_a", 64'(DIN_A), 64'd0);
    chk("rst_row_done", 64'(row_done), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_rows_filled", 64'(rows_filled), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(pix_ready), 64'd1);

    // First word of a frame.
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(negedge clk);
    chk("first_word_en", 64'(EN_A), 64'd1);
    chk("first_word_din", 64'(DIN_A), 64'h04030201);
    for (int c = 4; c < IW; c++) send(8'($urandom), 1'b0);

    // Fill all row buffers without releases.
    send_rows(3);
    repeat (2) @(negedge clk);
    chk("full_rows_filled", 64'(rows_filled), 64'd4);
    chk("full_not_ready", 64'(pix_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("full_holds", 64'(pix_ready), 64'd0);
    release_row();
    chk("release_ready", 64'(pix_ready), 64'd1);
    chk("release_rows_filled", 64'(rows_filled), 64'd3);
    send_rows(1);
    repeat (2) @(negedge clk);
    chk("refill_rows_filled", 64'(rows_filled), 64'd4);

    // row_done coinciding with a release leaves occupancy unchanged.
    release_row();
    release_row();
    chk("two_released", 64'(rows_filled), 64'd2);
    for (int c = 0; c < IW - 1; c++) send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    row_release = 1'b1;
    @(negedge clk);
    chk("rd_with_release", 64'(row_done), 64'd1);
    @(posedge clk); #1;
    row_release = 1'b0;
    @(negedge clk);
    chk("simul_rows_filled", 64'(rows_filled), 64'd2);

    // Remaining rows and the end-of-frame pulse.
    send_rows(1);
    release_row();
    for (int c = 0; c < IW - 1; c++) send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    @(negedge clk);
    chk("last_row_done", 64'(row_done), 64'd1);
    chk("fd_not_yet", 64'(frame_done), 64'd0);
    @(negedge clk);
    chk("fd_pulse", 64'(frame_done), 64'd1);
    chk("idle_ready", 64'(pix_ready), 64'd1);
    @(negedge clk);
    chk("fd_single", 64'(frame_done), 64'd0);
    chk("frame_rows_kept", 64'(rows_filled), 64'd3);

    // Pixels without sof in IDLE are dropped.
    for (int i = 0; i < int'(PPW); i++) send(8'(8'h50 + i), 1'b0);
    @(negedge clk);
    chk("idle_no_write", 64'(EN_A), 64'd0);

    // Reset in the middle of a word abandons it.
    send(8'h01, 1'b1); send(8'h02, 1'b0);
    rst = 1'b1;
    m_active = 1'b0; m_word = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_en", 64'(EN_A), 64'd0);
    chk("rst_mid_rows", 64'(rows_filled), 64'd0);
    release_row();
    chk("release_at_zero", 64'(rows_filled), 64'd0);
`ifdef RB_WR_PARTIAL_FLUSH_EN
    send(8'h11, 1'b1); send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);
    @(negedge clk);
    chk("flush_w0_din", 64'(DIN_A), 64'h14131211);
    send(8'h15, 1'b0); send(8'h16, 1'b0);
    @(negedge clk);
    chk("flush_w1_din", 64'(DIN_A), 64'h00001615);
    chk("flush_w1_addr", 64'(ADDR_A), 64'd1);
    chk("flush_w1_rd", 64'(row_done), 64'd1);
`else
    send(8'hA1, 1'b1); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    @(negedge clk);
    chk("restart_din", 64'(DIN_A), 64'hA4A3A2A1);
    chk("restart_addr", 64'(ADDR_A), 64'd0);
    chk("restart_bram_w", 64'(BRAM_W), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("fd_count", 64'(fd_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
